// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: validates A/B light codes and drives lamps, flashing yellow on sustained faults (optional LAMP_FAULT_COUNT_EN adds fault_count)
module traffic_lamp_monitor #(
  parameter int FAULT_DEBOUNCE = 2,
  parameter int BLINK_DIV      = 4,
  parameter int RECOVER_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] a_in,
  input  logic [2:0] b_in,
  input  logic       clear,
  output logic [2:0] lamp_a,
  output logic [2:0] lamp_b,
  output logic       fault,
  output logic [1:0] fault_code,
`ifdef LAMP_FAULT_COUNT_EN
  output logic [7:0] fault_count,
`endif
  output logic       flash_phase
);
  localparam int DW = $clog2(FAULT_DEBOUNCE + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, OFF = 3'b000;
  typedef enum logic [1:0] {NORMAL, PENDING, FAULT, RECOVER} state_t;
  state_t state, state_n;
  logic [2:0] la_n, lb_n, last_a, last_b, lla_n, llb_n;
  logic [1:0] c_n, cause;
  logic f_n, p_n, trip, legal, oh_a, oh_b;
  logic [DW-1:0] dcnt, dc_n;
  logic [BW-1:0] fcnt, fc_n;
  logic [RW-1:0] rcnt, rc_n;
  assign oh_a  = a_in == 3'b001 || a_in == 3'b010 || a_in == 3'b100;
  assign oh_b  = b_in == 3'b001 || b_in == 3'b010 || b_in == 3'b100;
  assign legal = oh_a && oh_b && (a_in == RED || b_in == RED);
  assign cause = (oh_a && oh_b) ? 2'b10 : 2'b01;
  // next-state and next-output decode; a trip overrides whatever the state chose
  always_comb begin
    state_n = state;
    la_n = lamp_a;
    lb_n = lamp_b;
    lla_n = last_a;
    llb_n = last_b;
    f_n = fault;
    c_n = fault_code;
    p_n = flash_phase;
    dc_n = dcnt;
    fc_n = fcnt;
    rc_n = rcnt;
    trip = 1'b0;
    case (state)
      NORMAL, PENDING: begin
        if (legal) begin
          state_n = NORMAL;
          la_n = a_in;
          lb_n = b_in;
          lla_n = a_in;
          llb_n = b_in;
          dc_n = '0;
        end else begin
          state_n = PENDING;
          la_n = last_a;
          lb_n = last_b;
          dc_n = dcnt + DW'(1);
          trip = dc_n == DW'(FAULT_DEBOUNCE);
        end
      end
      FAULT: begin
        if (clear && legal) begin
          state_n = RECOVER;
          la_n = RED;
          lb_n = RED;
          p_n = 1'b0;
          rc_n = '0;
        end else begin
          p_n = (fcnt == BW'(BLINK_DIV - 1)) ? ~flash_phase : flash_phase;
          fc_n = (fcnt == BW'(BLINK_DIV - 1)) ? '0 : fcnt + BW'(1);
          la_n = p_n ? YEL : OFF;
          lb_n = p_n ? YEL : OFF;
        end
      end
      RECOVER: begin
        trip = !legal;
        rc_n = legal ? rcnt + RW'(1) : rcnt;
        if (legal && rc_n == RW'(RECOVER_CYCLES)) begin
          state_n = NORMAL;
          la_n = a_in;
          lb_n = b_in;
          lla_n = a_in;
          llb_n = b_in;
          f_n = 1'b0;
          c_n = 2'b00;
          rc_n = '0;
        end
      end
    endcase
    if (trip) begin
      state_n = FAULT;
      f_n = 1'b1;
      c_n = cause;
      p_n = 1'b1;
      fc_n = '0;
      dc_n = '0;
      la_n = YEL;
      lb_n = YEL;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NORMAL;
      lamp_a <= RED;
      lamp_b <= RED;
      last_a <= RED;
      last_b <= RED;
      fault <= 1'b0;
      fault_code <= 2'b00;
      flash_phase <= 1'b0;
      dcnt <= '0;
      fcnt <= '0;
      rcnt <= '0;
    end else begin
      state <= state_n;
      lamp_a <= la_n;
      lamp_b <= lb_n;
      last_a <= lla_n;
      last_b <= llb_n;
      fault <= f_n;
      fault_code <= c_n;
      flash_phase <= p_n;
      dcnt <= dc_n;
      fcnt <= fc_n;
      rcnt <= rc_n;
    end
  end
`ifdef LAMP_FAULT_COUNT_EN
  // saturating count of FAULT entries, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) fault_count <= '0;
    else if (trip && fault_count != 8'hff) fault_count <= fault_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// tb_traffic_lamp_monitor: scoreboard bench with a behavioural reference model
module tb_traffic_lamp_monitor;
  localparam int DEB = 2, DIV = 4, REC = 8;
  logic clk = 0, reset = 1, clear = 0;
  logic [2:0] a_in = 3'b100, b_in = 3'b100, lamp_a, lamp_b;
  logic fault, flash_phase;
  logic [1:0] fault_code;
  logic [7:0] cnt_obs;
  int tests = 0, failed = 0;
  typedef struct {logic [2:0] la, lb; logic f; logic [1:0] c; logic p; logic [7:0] n;} exp_t;
  exp_t sb[$];
  int mst, dc, fc, rc;
  logic [2:0] mla, mlb, lla, llb;
  logic mf, mp;
  logic [1:0] mc;
  logic [7:0] mn;
  traffic_lamp_monitor dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .clear(clear),
    .lamp_a(lamp_a), .lamp_b(lamp_b), .fault(fault), .fault_code(fault_code),
`ifdef LAMP_FAULT_COUNT_EN
    .fault_count(cnt_obs),
`endif
    .flash_phase(flash_phase)
  );
`ifndef LAMP_FAULT_COUNT_EN
  assign cnt_obs = 8'd0;
`endif
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit oh(input logic [2:0] x);
    return x == 3'b001 || x == 3'b010 || x == 3'b100;
  endfunction
  task automatic enter_fault(input logic [1:0] cause);
    mst = 2; mf = 1; mc = cause; mp = 1; fc = 0; dc = 0; mla = 3'b010; mlb = 3'b010;
`ifdef LAMP_FAULT_COUNT_EN
    if (mn != 8'hff) mn++;
`endif
  endtask
  task automatic model(input logic [2:0] a, input logic [2:0] b, input logic clr, input logic rst);
    bit leg;
    logic [1:0] cause;
    leg = oh(a) && oh(b) && (a == 3'b100 || b == 3'b100);
    cause = (oh(a) && oh(b)) ? 2'b10 : 2'b01;
    if (rst) begin
      mst = 0; dc = 0; fc = 0; rc = 0; mla = 3'b100; mlb = 3'b100; lla = 3'b100; llb = 3'b100;
      mf = 0; mp = 0; mc = 0; mn = 0;
    end else if (mst <= 1) begin
      if (leg) begin
        mst = 0; dc = 0; mla = a; mlb = b; lla = a; llb = b;
      end else begin
        mst = 1; dc++; mla = lla; mlb = llb;
        if (dc >= DEB) enter_fault(cause);
      end
    end else if (mst == 2) begin
      if (clr && leg) begin
        mst = 3; rc = 0; mp = 0; mla = 3'b100; mlb = 3'b100;
      end else begin
        if (fc == DIV - 1) begin mp = !mp; fc = 0; end else fc++;
        mla = mp ? 3'b010 : 3'b000; mlb = mla;
      end
    end else begin
      if (!leg) enter_fault(cause);
      else begin
        rc++;
        if (rc == REC) begin
          mst = 0; rc = 0; mf = 0; mc = 0; mla = a; mlb = b; lla = a; llb = b;
        end
      end
    end
  endtask
  task automatic cyc(input logic [2:0] a, input logic [2:0] b, input logic clr, input logic rst);
    exp_t e;
    @(negedge clk);
    a_in = a; b_in = b; clear = clr; reset = rst;
    model(a, b, clr, rst);
    e = '{mla, mlb, mf, mc, mp, mn};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("lamp_a", {5'd0, lamp_a}, {5'd0, e.la});
    check("lamp_b", {5'd0, lamp_b}, {5'd0, e.lb});
    check("fault", {7'd0, fault}, {7'd0, e.f});
    check("fault_code", {6'd0, fault_code}, {6'd0, e.c});
    check("flash_phase", {7'd0, flash_phase}, {7'd0, e.p});
    check("fault_count", cnt_obs, e.n);
  endtask
  task automatic rep(input int n, input logic [2:0] a, input logic [2:0] b, input logic clr);
    for (int i = 0; i < n; i++) cyc(a, b, clr, 0);
  endtask
  logic [2:0] legal_tab [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  logic [2:0] legal_tb [5] = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  initial begin
    cyc(3'b100, 3'b100, 0, 1);
    check("reset_lamp_a", {5'd0, lamp_a}, 8'h04);
    check("reset_fault", {7'd0, fault}, 8'h00);
    cyc(3'b001, 3'b100, 0, 0);
    cyc(3'b010, 3'b100, 0, 0);
    cyc(3'b100, 3'b001, 0, 0);
    cyc(3'b100, 3'b010, 0, 0);
    cyc(3'b001, 3'b100, 0, 0);
    cyc(3'b001, 3'b001, 0, 0);
    check("debounce_hold", {5'd0, lamp_a}, 8'h01);
    cyc(3'b010, 3'b100, 0, 0);
    rep(2, 3'b011, 3'b100, 0);
    check("trip_fault", {7'd0, fault}, 8'h01);
    check("trip_code", {6'd0, fault_code}, 8'h01);
    rep(12, 3'b011, 3'b100, 0);
    rep(2, 3'b001, 3'b001, 1);
    check("clear_illegal_ignored", {7'd0, fault}, 8'h01);
    cyc(3'b100, 3'b100, 1, 0);
    rep(7, 3'b100, 3'b100, 0);
    check("recover_still_fault", {7'd0, fault}, 8'h01);
    cyc(3'b100, 3'b100, 0, 0);
    check("recovered", {7'd0, fault}, 8'h00);
    cyc(3'b001, 3'b100, 0, 0);
    rep(2, 3'b000, 3'b100, 0);
    rep(3, 3'b000, 3'b100, 0);
    cyc(3'b100, 3'b100, 1, 0);
    rep(5, 3'b100, 3'b001, 0);
    cyc(3'b001, 3'b010, 0, 0);
    check("reinject_code", {6'd0, fault_code}, 8'h02);
    check("reinject_phase", {7'd0, flash_phase}, 8'h01);
    rep(3, 3'b001, 3'b010, 0);
    cyc(3'b001, 3'b010, 0, 1);
    check("midfault_reset", {7'd0, fault}, 8'h00);
    rep(2, 3'b100, 3'b001, 0);
    for (int i = 0; i < 400; i++) begin
      int k = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0)
        cyc(3'($urandom), 3'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
      else
        cyc(legal_tab[k], legal_tb[k], $urandom_range(0, 3) == 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
